// File: rtl/bcd_bin_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_bin_if                                                |
// | Purpose  : Request/result bundle for the BCD-to-binary converter.    |
// |            The requester drives start_i/bcd_i. The converter         |
// |            returns bin_o, valid_o, busy_o and err_o.                 |
// | Signals  : start_i  1   conversion request                           |
// |            bcd_i   24   six packed BCD digits                        |
// |            bin_o   20   binary result                                |
// |            valid_o  1   one-cycle completion pulse                   |
// |            busy_o   1   conversion in progress                       |
// |            err_o    1   last accepted request had a digit > 9        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface bcd_bin_if;
  logic        start_i;
  logic [23:0] bcd_i;
  logic [19:0] bin_o;
  logic        valid_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output start_i, bcd_i,
    input  bin_o, valid_o, busy_o, err_o
  );

  modport slave (
    input  start_i, bcd_i,
    output bin_o, valid_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/bcd_bin.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_bin                                                   |
// | Purpose  : Six-digit BCD to 20-bit binary converter. It uses         |
// |            iterative reverse double-dabble, one bit per cycle, and   |
// |            takes 20 cycles for each conversion.                      |
// | Ports    : clk_i   in   1  clock, rising edge                        |
// |            rst_i   in   1  synchronous reset, active-high            |
// |            bus     slave   bcd_bin_if (start_i, bcd_i in;            |
// |                            bin_o, valid_o, busy_o, err_o out)        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bcd_bin (
  input  wire         clk_i,
  input  wire         rst_i,
  bcd_bin_if.slave    bus
);

  localparam int          NUM_DIGITS = 6;
  localparam logic [4:0]  LAST_ITER  = 5'd19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [43:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] bin_q, bin_d;
  logic        err_q, err_d;

  logic [43:0] work_shifted;
  logic [43:0] work_step;
  logic [NUM_DIGITS-1:0] digit_bad;

  // One reverse double-dabble step: shift right, then correct each BCD field.
  // A field of 8 or more means the bit that just moved in from the next digit
  // up is worth 10 in this digit, not 16. Subtracting 3 rescales it
  // (16/2 = 8 -> 10/2 = 5), so the field stays within 0..9 and cannot borrow
  // across digits.
  assign work_shifted = {1'b0, work_q[43:1]};
  assign work_step[19:0] = work_shifted[19:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_fix
    assign work_step[20+4*g +: 4] = (work_shifted[20+4*g +: 4] >= 4'd8)
                                  ? work_shifted[20+4*g +: 4] - 4'd3
                                  : work_shifted[20+4*g +: 4];
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_chk
    assign digit_bad[g] = (bus.bcd_i[4*g +: 4] > 4'd9);
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (|digit_bad) begin
            // A malformed request completes at once with a zero result.
            state_d = DONE;
            err_d   = 1'b1;
            bin_d   = 20'd0;
          end else begin
            state_d = SHIFT;
            work_d  = {bus.bcd_i, 20'd0};
            cnt_d   = 5'd0;
            err_d   = 1'b0;
          end
        end
      end
      SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          bin_d   = work_step[19:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= 44'd0;
      cnt_q   <= 5'd0;
      bin_q   <= 20'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bus.bin_o   = bin_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = (state_q == SHIFT);
  assign bus.valid_o = (state_q == DONE);

endmodule
`default_nettype wire
